// File: rtl/exp_pkg.sv
// Shared widths, fixed-point constants and the 1/K coefficient table for the e^x series datapath.
// Every value here is Q-format with 16 fraction bits.
package exp_pkg;

    localparam int XW_DEF    = 16;
    localparam int TW_DEF    = 17;
    localparam int RW_DEF    = 18;
    localparam int FRAC_BITS = 16;
    localparam int KW        = 3;
    localparam int COEF_W    = 17;

    localparam logic [COEF_W-1:0] ONE_Q16 = 17'd65536;
    localparam logic [KW-1:0]     K_LAST  = 3'd7;

    // Entry K holds floor(65536 / K); entry 0 is unused by the series and reads as zero.
    localparam logic [COEF_W-1:0] COEF_TABLE [0:7] = '{
        17'd0,
        17'd65536,
        17'd32768,
        17'd21845,
        17'd16384,
        17'd13107,
        17'd10922,
        17'd9362
    };

endpackage

// File: rtl/exp_coef_rom.sv
// Combinational 1/K lookup (Q1.16) indexed by the term counter.
module exp_coef_rom
    import exp_pkg::*;
(
    input  logic [KW-1:0]     k_i,
    output logic [COEF_W-1:0] coef_o
);

    always_comb begin
        coef_o = COEF_TABLE[k_i];
    end

endmodule

// File: rtl/exp_datapath.sv
// Register/multiplier datapath for e^x = sum x^k/k!; an external controller sequences the steps.
// One shared multiplier builds each term as (T*x)/k.
module exp_datapath
    import exp_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int TW = TW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [XW-1:0] x_in,
    input  logic          initx,
    input  logic          ldx,
    input  logic          initt,
    input  logic          ldt,
    input  logic          initr,
    input  logic          ldr,
    input  logic          ldc,
    input  logic          enc,
    input  logic          s,
    output logic          co,
    output logic [RW-1:0] result
);

    localparam int OPW = (XW > COEF_W) ? XW : COEF_W;
    localparam int PW  = TW + OPW;
    localparam int SW  = RW + 1;

    logic [XW-1:0]     x_q, x_d;
    logic [TW-1:0]     t_q, t_d;
    logic [RW-1:0]     r_q, r_d;
    logic [KW-1:0]     k_q, k_d;

    logic [COEF_W-1:0] coef;
    logic [OPW-1:0]    multOperand;
    logic [TW-1:0]     multOut;
    logic [SW-1:0]     rSum;

    exp_coef_rom u_coef_rom (
        .k_i    (k_q),
        .coef_o (coef)
    );

    // Product is shifted back to Q1.16 and truncated to TW bits; no rounding.
    always_comb begin
        multOperand = s ? OPW'(coef) : OPW'(x_q);
        multOut     = TW'((PW'(t_q) * PW'(multOperand)) >> FRAC_BITS);
        rSum        = {1'b0, r_q} + SW'(t_q);
    end

    always_comb begin
        x_d = x_q;
        t_d = t_q;
        r_d = r_q;
        k_d = k_q;

        if (initx) begin
            x_d = '0;
        end else if (ldx) begin
            x_d = x_in;
        end

        if (initt) begin
            t_d = TW'(ONE_Q16);
        end else if (ldt) begin
            t_d = multOut;
        end

        // The carry out of the accumulator pins R at full scale instead of wrapping.
        if (initr) begin
            r_d = '0;
        end else if (ldr) begin
            r_d = rSum[RW] ? '1 : rSum[RW-1:0];
        end

        if (ldc) begin
            k_d = KW'(1);
        end else if (enc) begin
            k_d = k_q + KW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q <= '0;
            t_q <= '0;
            r_q <= '0;
            k_q <= '0;
        end else begin
            x_q <= x_d;
            t_q <= t_d;
            r_q <= r_d;
            k_q <= k_d;
        end
    end

    assign co     = (k_q == K_LAST);
    assign result = r_q;

endmodule

// File: tb/tb_exp_datapath.sv
// Directed bench for exp_datapath: an arithmetic model of X/T/R/K is checked every cycle,
// and literal end results pin the model and the DUT for known series runs.
module tb_exp_datapath;

    localparam int XW = 16;
    localparam int TW = 17;
    localparam int RW = 18;
    localparam longint RMAX = (64'd1 << RW) - 1;

    localparam logic [8:0] INITX = 9'h100;
    localparam logic [8:0] LDX   = 9'h080;
    localparam logic [8:0] INITT = 9'h040;
    localparam logic [8:0] LDT   = 9'h020;
    localparam logic [8:0] INITR = 9'h010;
    localparam logic [8:0] LDR   = 9'h008;
    localparam logic [8:0] LDC   = 9'h004;
    localparam logic [8:0] ENC   = 9'h002;
    localparam logic [8:0] SEL   = 9'h001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [XW-1:0] x_in = '0;
    logic          initx = 1'b0, ldx = 1'b0, initt = 1'b0, ldt = 1'b0;
    logic          initr = 1'b0, ldr = 1'b0, ldc = 1'b0, enc = 1'b0, s = 1'b0;
    logic          co;
    logic [RW-1:0] result;

    int checks = 0;
    int failures = 0;
    bit compareOn = 1'b0;

    longint mX = 0, mT = 0, mR = 0, mK = 0;
    longint opnd, nT, nR, nK;

    exp_datapath #(.XW(XW), .TW(TW), .RW(RW)) dut (
        .clk    (clk),
        .rst    (rst),
        .x_in   (x_in),
        .initx  (initx),
        .ldx    (ldx),
        .initt  (initt),
        .ldt    (ldt),
        .initr  (initr),
        .ldr    (ldr),
        .ldc    (ldc),
        .enc    (enc),
        .s      (s),
        .co     (co),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic longint coefModel(input longint k);
        return (k == 0) ? 0 : (65536 / k);
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Drive one control word just after a rising edge; it is consumed by the following edge.
    task automatic applyStimulus(input logic [8:0] ctrl);
        @(posedge clk);
        #2;
        {initx, ldx, initt, ldt, initr, ldr, ldc, enc, s} = ctrl;
    endtask

    // Series arithmetic: term T becomes floor(T*x) then floor(T/k), R sums terms with a ceiling.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mX = 0;
            mT = 0;
            mR = 0;
            mK = 0;
        end else begin
            opnd = s ? coefModel(mK) : mX;
            nT   = ((mT * opnd) >> 16) & 64'h1FFFF;
            nR   = mR + mT;
            if (nR > RMAX) nR = RMAX;
            nK   = (mK + 1) % 8;
            if (initx) mX = 0; else if (ldx) mX = longint'(x_in);
            if (initt) mT = 65536; else if (ldt) mT = nT;
            if (initr) mR = 0; else if (ldr) mR = nR;
            if (ldc) mK = 1; else if (enc) mK = nK;
        end
    end

    always @(negedge clk) begin
        if (compareOn) begin
            checkOutput("cycle_result", longint'(result), mR);
            checkOutput("cycle_co", longint'(co), (mK == 7) ? 1 : 0);
        end
    end

    task automatic runExp(input logic [XW-1:0] xv, input string tag);
        x_in = xv;
        applyStimulus(INITX | INITT | INITR);
        applyStimulus(LDX | LDC | LDR);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(LDT);
            if (i > 0) checkOutput({tag, "_co_after_enc"}, longint'(co), (i == 6) ? 1 : 0);
            applyStimulus(LDT | SEL);
            applyStimulus(LDR);
            applyStimulus(ENC);
        end
        applyStimulus(0);
        checkOutput({tag, "_co_after_wrap"}, longint'(co), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst = 1'b0;
        compareOn = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_result", longint'(result), 0);
        checkOutput("reset_co", longint'(co), 0);
        rst = 1'b1;

        runExp(16'd0, "x0");
        checkOutput("x0_result", longint'(result), 65536);

        runExp(16'd32768, "xhalf");
        checkOutput("xhalf_result", longint'(result), 108048);
        checkOutput("xhalf_within_8", (result >= 18'd108043 && result <= 18'd108059) ? 1 : 0, 1);

        runExp(16'd65535, "xmax");
        checkOutput("xmax_result", longint'(result), 178136);
        checkOutput("xmax_within_16", (result >= 18'd178129 && result <= 18'd178161) ? 1 : 0, 1);

        applyStimulus(INITT | INITR | LDC);
        repeat (4) applyStimulus(ENC);
        applyStimulus(LDC | ENC);
        repeat (5) applyStimulus(ENC);
        applyStimulus(ENC);
        checkOutput("ldc_over_enc_k6", longint'(co), 0);
        applyStimulus(0);
        checkOutput("ldc_over_enc_k7", longint'(co), 1);

        x_in = 16'd32768;
        applyStimulus(LDX | INITT | INITR);
        applyStimulus(LDT);
        applyStimulus(INITT | LDT);
        applyStimulus(LDR);
        applyStimulus(0);
        checkOutput("initt_over_ldt", longint'(result), 65536);

        applyStimulus(INITT | INITR);
        repeat (4) applyStimulus(LDR);
        applyStimulus(0);
        checkOutput("sat_reach", longint'(result), 262143);
        applyStimulus(LDR);
        applyStimulus(0);
        checkOutput("sat_hold", longint'(result), 262143);

        x_in = 16'd32768;
        applyStimulus(INITX | INITT | INITR);
        applyStimulus(LDX | LDC | LDR);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(LDT);
            applyStimulus(LDT | SEL);
            applyStimulus(LDR);
            applyStimulus(ENC);
        end
        applyStimulus(LDT);
        @(posedge clk);
        #2;
        rst = 1'b0;
        {initx, ldx, initt, ldt, initr, ldr, ldc, enc, s} = LDX | INITT | LDR | LDC | ENC;
        #1;
        checkOutput("midrun_reset_result", longint'(result), 0);
        checkOutput("midrun_reset_co", longint'(co), 0);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_ignores_ctrl", longint'(result), 0);
        {initx, ldx, initt, ldt, initr, ldr, ldc, enc, s} = 9'h000;
        rst = 1'b1;

        applyStimulus(LDR);
        applyStimulus(0);
        checkOutput("post_reset_t_zero", longint'(result), 0);
        repeat (7) applyStimulus(ENC);
        applyStimulus(0);
        checkOutput("post_reset_k7", longint'(co), 1);
        applyStimulus(ENC);
        applyStimulus(0);
        checkOutput("wrap_co_low", longint'(co), 0);

        repeat (2) @(posedge clk);
        compareOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exp_datapath.md
EXP_DATAPATH -- requirements
Module: exp_datapath

Interface
REQ-001 Parameter XW, default 16, width of x operand (Q0.16 unsigned).
REQ-002 Parameter TW, default 17, width of term register T (Q1.16).
REQ-003 Parameter RW, default 18, width of result register R (Q2.16).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 x_in  input  XW  operand x, fraction in [0,1).
REQ-007 initx, ldx  input  1 each  clear X / load X from x_in.
REQ-008 initt, ldt  input  1 each  set T to 1.0 / load T from multiplier.
REQ-009 initr, ldr  input  1 each  clear R / accumulate R += T.
REQ-010 ldc, enc  input  1 each  load counter K with 1 / increment K.
REQ-011 s  input  1  multiplier operand select (0: T*X, 1: T*coef[K]).
REQ-012 co  output  1  counter terminal flag, combinational, K == 7.
REQ-013 result  output  RW  current R value, Q2.16.

Function
REQ-014 Block SHALL compute e^x = sum of x^k/k! for k = 0..7, stepped by an external controller.
REQ-015 X SHALL: initx -> 0; else ldx -> x_in; else hold.
REQ-016 T SHALL: initt -> 65536 (1.0); else ldt -> mult_out; else hold.
REQ-017 R SHALL: initr -> 0; else ldr -> R + T (zero-extended); else hold.
REQ-018 K (3 bits) SHALL: ldc -> 1; else enc -> K+1, wrapping 7 -> 0; else hold.
REQ-019 Single shared multiplier; s=0: mult_out = (T*X) >> 16; s=1: mult_out = (T*coef[K]) >> 16; truncation, no rounding.
REQ-020 coef[K] SHALL be 1/K in Q1.16: 65536, 32768, 21845, 16384, 13107, 10922, 9362 for K = 1..7; coef[0] = 0.
REQ-021 Intended per-term sequence: ldt with s=0, then ldt with s=1, then ldr, then enc; the datapath SHALL NOT enforce ordering.
REQ-022 Each control input SHALL take effect on the edge it is sampled at; latency one cycle, no pipelining.
REQ-023 Init SHALL override load on the same register in the same cycle; ldc SHALL override enc.
REQ-024 R SHALL saturate at 2^RW-1 rather than wrap; T truncates to TW bits (cannot overflow for x < 1).
REQ-025 co SHALL follow K combinationally; deasserts the cycle after K wraps.
REQ-026 Asserting control inputs while rst is low SHALL have no effect.

Reset
REQ-027 On rst low, X = 0, T = 0, R = 0, K = 0 immediately; co = 0, result = 0.
REQ-028 Reset mid-computation SHALL discard all partial state; the next start requires a full init sequence.

Structure
REQ-029 Package exp_pkg SHALL hold XW/TW/RW defaults, ONE_Q16 = 65536, K width, and the coefficient table.
REQ-030 Coefficient lookup SHALL be one sub-module, exp_coef_rom (K in, coef out, combinational).
REQ-031 The block SHALL contain no FSM; sequencing stays in the controller.

Verification
REQ-032 x_in=0, init all, ldx, ldc, 7 term iterations -> result = 65536, co high after 6th enc.
REQ-033 x_in=32768 (0.5), full run -> result within 8 LSB of 108051 (e^0.5).
REQ-034 x_in=65535, full run -> result within 16 LSB of 178145; no saturation.
REQ-035 ldc and enc together at K=5 -> K = 1; initt and ldt together -> T = 65536.
REQ-036 rst low mid-run (K=4) -> all registers 0 same cycle; controls ignored until rst high.
REQ-037 enc at K=7 -> K = 0, co deasserts next cycle.
